// File: rtl/diaosi_types_pkg.sv
// Shared types for the cache-to-memory request path.
package diaosi_types_pkg;

    // Width of the access-latency down-counter (covers latencies 1..15).
    localparam int CNT_W = 4;

    // Arbiter states: idle, serving the icache, serving the dcache.
    typedef enum logic [1:0] {
        IDLE,
        IBUSY,
        DBUSY
    } memctl_state_t;

    // A request captured at grant time and replayed to the RAM while busy.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        write;
    } memctl_req_t;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that measures the remaining busy cycles of one RAM access.
module mem_lat_counter
    import diaosi_types_pkg::*;
(
    input  logic             CLK,
    input  logic             nRST,
    input  logic             load_i,
    input  logic [CNT_W-1:0] loadVal_i,
    input  logic             dec_i,
    input  logic             clear_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear wins over load so an abort always leaves the counter at rest; decrement saturates at zero.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = loadVal_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/memory_control.sv
// Arbitrates icache fetches and dcache accesses onto a single-ported fixed-latency RAM.
module memory_control
    import diaosi_types_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload
);

    localparam logic [CNT_W-1:0] LoadVal = CNT_W'(LAT - 1);

    memctl_state_t state_q, state_d;
    memctl_req_t   req_q, req_d;

    logic dReq;
    logic grantEn;
    logic busy;
    logic active;
    logic abort;
    logic cntZero;
    logic done;
    logic startAccess;

    // A busy access stays alive only while the granted requester keeps its enable high.
    assign dReq        = dREN | dWEN;
    assign grantEn     = (state_q == IBUSY) ? iREN : dReq;
    assign busy        = (state_q != IDLE);
    assign active      = busy && grantEn;
    assign abort       = busy && !grantEn;
    assign done        = active && cntZero;
    assign startAccess = (state_q == IDLE) && (dReq || iREN);

    mem_lat_counter u_cnt (
        .CLK       (CLK),
        .nRST      (nRST),
        .load_i    (startAccess),
        .loadVal_i (LoadVal),
        .dec_i     (active),
        .clear_i   (abort),
        .zero_o    (cntZero)
    );

    // Next-state logic: data wins arbitration; completion or abort always returns to IDLE.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (dReq) begin
                    state_d     = DBUSY;
                    req_d.addr  = daddr;
                    req_d.data  = dstore;
                    req_d.write = dWEN;
                end else if (iREN) begin
                    state_d     = IBUSY;
                    req_d.addr  = iaddr;
                    req_d.data  = '0;
                    req_d.write = 1'b0;
                end
            end
            IBUSY, DBUSY: begin
                if (abort || done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and request latch registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    // Output muxing: writes commit only on the completion cycle, read data passes straight through.
    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (active) begin
            ramaddr = req_q.addr;
            if (req_q.write) begin
                ramstore = req_q.data;
                ramWEN   = done;
            end else begin
                ramREN = 1'b1;
            end
            if (done) begin
                if (state_q == IBUSY) begin
                    iwait = 1'b0;
                    iload = ramload;
                end else begin
                    dwait = 1'b0;
                    dload = req_q.write ? 32'd0 : ramload;
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_control.sv
// Self-checking bench for memory_control: directed vector table, reset recovery, randomized model comparison.
module tb_memory_control;

    localparam int LAT = 2;
    localparam int RAND_CYCLES = 3000;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;

    int checks = 0;
    int failures = 0;

    memory_control #(.LAT(LAT)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload)
    );

    // Free-running clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Initial RAM contents, known independently to the bench's reference memory.
    function automatic logic [31:0] initWord(input int a);
        logic [31:0] w;
        if (a == 32'h40) begin
            w = 32'hDEADBEEF;
        end else begin
            w = (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
        end
        return w;
    endfunction

    // Behavioural RAM: data valid only once LAT-1 further read cycles have passed since the first ramREN.
    logic [31:0] tbRam [0:255];
    int          ramBusyCnt;
    logic        fillReq;

    always @(posedge CLK) begin
        if (fillReq) begin
            for (int i = 0; i < 256; i++) tbRam[i] <= initWord(i);
        end else if (ramWEN) begin
            tbRam[ramaddr[7:0]] <= ramstore;
        end
        if (ramREN) ramBusyCnt <= ramBusyCnt + 1;
        else        ramBusyCnt <= 0;
    end

    assign ramload = (ramREN && ramBusyCnt == LAT - 1) ? tbRam[ramaddr[7:0]] : 32'hBAADF00D;

    // Stall guard so the bench always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        string       name;
        logic        iREN;
        logic        dREN;
        logic        dWEN;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] dstore;
        logic        eIwait;
        logic        eDwait;
        logic        eRamREN;
        logic        eRamWEN;
        logic [31:0] eIload;
        logic [31:0] eDload;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic i, logic r, logic w, logic [31:0] ia, logic [31:0] da,
                                logic [31:0] ds, logic eiw, logic edw, logic err, logic erw,
                                logic [31:0] eil, logic [31:0] edl);
        vec_t v;
        v.name = n; v.iREN = i; v.dREN = r; v.dWEN = w; v.iaddr = ia; v.daddr = da; v.dstore = ds;
        v.eIwait = eiw; v.eDwait = edw; v.eRamREN = err; v.eRamWEN = erw; v.eIload = eil; v.eDload = edl;
        return v;
    endfunction

    task automatic applyStimulus(input logic i, input logic r, input logic w, input logic [31:0] ia,
                                 input logic [31:0] da, input logic [31:0] ds);
        iREN = i; dREN = r; dWEN = w; iaddr = ia; daddr = da; dstore = ds;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30)
                $display("[TB] FAIL %s at %0t: got 0x%08h, required 0x%08h", name, $time, act, exp);
        end
    endtask

    // Reference model state for randomized checking: who is granted and how many busy cycles remain.
    int          mWho;
    int          mLeft;
    logic [31:0] mAddr;
    logic [31:0] mData;
    logic        mWrite;
    logic [31:0] modelMem [0:255];

    initial begin
        logic        en, fin, eIw, eDw, eRR, eRW;
        logic [31:0] eIl, eDl;
        int          n;

        fillReq = 1'b1;
        nRST    = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        #3;
        checkOutput("resetWaits", {30'd0, iwait, dwait}, 32'd3);
        checkOutput("resetEnables", {30'd0, ramREN, ramWEN}, 32'd0);
        checkOutput("resetLoads", iload | dload | ramaddr | ramstore, 32'd0);
        @(posedge CLK); #1;
        fillReq = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK); #1;

        // Directed vectors with LAT=2: each row is one clock cycle.
        vecs.push_back(mk("ifetchReq",   1,0,0, 32'h40, 0, 0,              1,1,0,0, 0, 0));
        vecs.push_back(mk("ifetchBusy",  1,0,0, 32'h99, 0, 0,              1,1,1,0, 0, 0));
        vecs.push_back(mk("ifetchDone",  1,0,0, 32'h99, 0, 0,              0,1,1,0, 32'hDEADBEEF, 0));
        vecs.push_back(mk("idleGap",     0,0,0, 0, 0, 0,                   1,1,0,0, 0, 0));
        vecs.push_back(mk("dwriteReq",   0,0,1, 0, 32'h80, 32'h12345678,   1,1,0,0, 0, 0));
        vecs.push_back(mk("dwriteBusy",  0,0,1, 0, 32'h80, 32'h12345678,   1,1,0,0, 0, 0));
        vecs.push_back(mk("dwriteDone",  0,0,1, 0, 32'h80, 32'h12345678,   1,0,0,1, 0, 0));
        vecs.push_back(mk("dreadReq",    0,1,0, 0, 32'h80, 0,              1,1,0,0, 0, 0));
        vecs.push_back(mk("dreadBusy",   0,1,0, 0, 32'h11, 0,              1,1,1,0, 0, 0));
        vecs.push_back(mk("dreadDone",   0,1,0, 0, 32'h11, 0,              1,0,1,0, 0, 32'h12345678));
        vecs.push_back(mk("bothReq",     1,1,0, 32'h44, 32'h80, 0,         1,1,0,0, 0, 0));
        vecs.push_back(mk("bothDBusy",   1,1,0, 32'h44, 32'h80, 0,         1,1,1,0, 0, 0));
        vecs.push_back(mk("bothDDone",   1,1,0, 32'h44, 32'h80, 0,         1,0,1,0, 0, 32'h12345678));
        vecs.push_back(mk("iAfterDIdle", 1,0,0, 32'h44, 0, 0,              1,1,0,0, 0, 0));
        vecs.push_back(mk("iAfterDBusy", 1,0,0, 32'h44, 0, 0,              1,1,1,0, 0, 0));
        vecs.push_back(mk("iAfterDDone", 1,0,0, 32'h44, 0, 0,              0,1,1,0, initWord(32'h44), 0));
        vecs.push_back(mk("rwReq",       0,1,1, 0, 32'h90, 32'hCAFEF00D,   1,1,0,0, 0, 0));
        vecs.push_back(mk("rwBusy",      0,1,1, 0, 32'h90, 32'hCAFEF00D,   1,1,0,0, 0, 0));
        vecs.push_back(mk("rwDone",      0,1,1, 0, 32'h90, 32'hCAFEF00D,   1,0,0,1, 0, 0));
        vecs.push_back(mk("abortReq",    0,0,1, 0, 32'h80, 32'hFFFF0000,   1,1,0,0, 0, 0));
        vecs.push_back(mk("abortDrop",   0,0,0, 0, 32'h80, 32'hFFFF0000,   1,1,0,0, 0, 0));
        vecs.push_back(mk("postAbortReq",0,1,0, 0, 32'h80, 0,              1,1,0,0, 0, 0));
        vecs.push_back(mk("postAbortBsy",0,1,0, 0, 32'h80, 0,              1,1,1,0, 0, 0));
        vecs.push_back(mk("postAbortDn", 0,1,0, 0, 32'h80, 0,              1,0,1,0, 0, 32'h12345678));
        vecs.push_back(mk("read90Req",   0,1,0, 0, 32'h90, 0,              1,1,0,0, 0, 0));
        vecs.push_back(mk("read90Busy",  0,1,0, 0, 32'h90, 0,              1,1,1,0, 0, 0));
        vecs.push_back(mk("read90Done",  0,1,0, 0, 32'h90, 0,              1,0,1,0, 0, 32'hCAFEF00D));
        vecs.push_back(mk("finalIdle",   0,0,0, 0, 0, 0,                   1,1,0,0, 0, 0));

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].iREN, vecs[k].dREN, vecs[k].dWEN, vecs[k].iaddr, vecs[k].daddr, vecs[k].dstore);
            @(negedge CLK);
            checkOutput({vecs[k].name, ".waits"}, {30'd0, iwait, dwait}, {30'd0, vecs[k].eIwait, vecs[k].eDwait});
            checkOutput({vecs[k].name, ".ramEn"}, {30'd0, ramREN, ramWEN}, {30'd0, vecs[k].eRamREN, vecs[k].eRamWEN});
            checkOutput({vecs[k].name, ".iload"}, iload, vecs[k].eIload);
            checkOutput({vecs[k].name, ".dload"}, dload, vecs[k].eDload);
            @(posedge CLK); #1;
        end

        // Asynchronous reset in the middle of an instruction fetch, then a fresh fetch.
        applyStimulus(1, 0, 0, 32'h40, 0, 0);
        @(posedge CLK); #1;
        checkOutput("preResetBusy", {31'd0, ramREN}, 32'd1);
        nRST = 1'b0;
        #1;
        checkOutput("midResetWaits", {30'd0, iwait, dwait}, 32'd3);
        checkOutput("midResetRamREN", {31'd0, ramREN}, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        n = 0;
        while (iwait !== 1'b0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("resetRecoveryLatency", n, LAT);
        checkOutput("resetRecoveryLoad", iload, 32'hDEADBEEF);
        @(posedge CLK); #1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        checkOutput("resetRecoveryPulse", {31'd0, iwait}, 32'd1);
        @(posedge CLK); #1;

        // Randomized traffic against a transaction-level model of the arbiter.
        for (int i = 0; i < 256; i++) modelMem[i] = initWord(i);
        mWho = 0; mLeft = 0; mAddr = 0; mData = 0; mWrite = 0;
        for (int c = 0; c < RAND_CYCLES; c++) begin
            if ($urandom_range(0, 4) == 0) iREN = ~iREN;
            if ($urandom_range(0, 4) == 0) dREN = ~dREN;
            if ($urandom_range(0, 9) == 0) dWEN = ~dWEN;
            iaddr  = 32'($urandom_range(0, 15));
            daddr  = 32'($urandom_range(0, 15));
            dstore = $urandom;
            @(negedge CLK);
            eIw = 1; eDw = 1; eRR = 0; eRW = 0; eIl = 0; eDl = 0; en = 0; fin = 0;
            if (mWho != 0) begin
                en = (mWho == 1) ? iREN : (dREN | dWEN);
                if (en) begin
                    fin = (mLeft == 1);
                    if (mWrite) eRW = fin; else eRR = 1;
                    if (fin) begin
                        if (mWho == 1) begin
                            eIw = 0; eIl = modelMem[mAddr[7:0]];
                        end else begin
                            eDw = 0;
                            if (!mWrite) eDl = modelMem[mAddr[7:0]];
                        end
                    end
                end
            end
            checkOutput("rnd.waits", {30'd0, iwait, dwait}, {30'd0, eIw, eDw});
            checkOutput("rnd.ramEn", {30'd0, ramREN, ramWEN}, {30'd0, eRR, eRW});
            checkOutput("rnd.iload", iload, eIl);
            checkOutput("rnd.dload", dload, eDl);
            if (en) checkOutput("rnd.ramaddr", ramaddr, mAddr);
            if (eRW) checkOutput("rnd.ramstore", ramstore, mData);
            if (mWho == 0) begin
                if (dREN | dWEN) begin
                    mWho = 2; mLeft = LAT; mAddr = daddr; mData = dstore; mWrite = dWEN;
                end else if (iREN) begin
                    mWho = 1; mLeft = LAT; mAddr = iaddr; mData = 0; mWrite = 0;
                end
            end else if (!en) begin
                mWho = 0;
            end else if (fin) begin
                if (mWrite) modelMem[mAddr[7:0]] = mData;
                mWho = 0;
            end else begin
                mLeft--;
            end
            @(posedge CLK); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
